multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multi-cycle 16-bit RISC datapath. It combines the per-opcode static control decode with a FETCH/DECODE/EXEC/MEM/WB state machine that gates all write strobes. It adds a data-memory ready handshake with a parametrised timeout, illegal-opcode trapping for wider opcode fields, and a retired-instruction counter. It sits between the instruction register and the datapath muxes and enables.

## Interface
- OPCODE_W, 4: opcode field width, minimum 4; values ≥16 are illegal.
- MEM_TIMEOUT, 15: maximum MEM cycles without `mem_ready`; 0 disables the timeout.
- CNT_W, 16: width of `retire_cnt`.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  opcode from the IR; stable from DECODE onward.
- mode  in  1  IR mode bit.
- branch_taken  in  1  datapath branch condition, sampled in EXEC.
- mem_ready  in  1  data-memory completion, sampled only in MEM.
- pc_wr, ir_wr, reg_wr, mem_rd, mem_wr  out  1 each  state-gated strobes.
- pc_src  out  2  next PC: 0 = PC+1, 1 = jump target, 2 = RA, 3 = branch target.
- ra_src  out  2  RA select: 0 = Rs, 1 = R7, 2 = Rd.
- wb_sel  out  2  writeback data: 0 = ALU, 1 = memory, 2 = return address.
- rb_src, reg_dst, ext_op, alu_src, sv_imm, ext_op_mem, mem_out  out  1 each  static datapath selects.
- state  out  3  FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 5.
- fault  out  1  high while in FAULT.
- retire_cnt  out  CNT_W  completed-instruction count; wraps modulo 2^CNT_W.

## Operation
- **Static selects.** These are combinational from opcode and mode in every state. Any field not used by an opcode is driven 0, never X.
  - R-type (0–2): all selects 0.
  - ADDI (3): ext_op = 1, alu_src = 1.
  - ANDI (4): ext_op = 0, alu_src = 1.
  - LW (5): rb_src = 1, ext_op = 1, alu_src = 1, wb_sel = 1.
  - LB (6): as LW, plus mem_out = 1 and ext_op_mem = mode.
  - SW (7): rb_src = 1, ext_op = 1, alu_src = 1.
  - Branch (8–11): rb_src = 1; ra_src = 2 if mode = 1, else 0.
  - CALL (13): reg_dst = 1, wb_sel = 2.
  - RET (14): ra_src = 1.
  - SV (15): ext_op = 1, sv_imm = 1.
- **FETCH:** assert ir_wr and pc_wr with pc_src = 0. Next state DECODE.
- **DECODE:**
  - Illegal opcode: next state FAULT.
  - JMP: pc_wr with pc_src = 1, next FETCH.
  - RET: pc_wr with pc_src = 2, next FETCH.
  - CALL: next WB.
  - All other opcodes: next EXEC.
- **EXEC:**
  - Branch: pc_wr = branch_taken with pc_src = 3, next FETCH.
  - Opcodes 0–4: next WB.
  - Opcodes 5, 6, 7, 15: next MEM.
- **MEM:**
  - mem_rd is asserted for opcodes 5–6; mem_wr for opcodes 7 and 15. The strobe is held every MEM cycle, up to and including the cycle in which mem_ready is high.
  - On mem_ready: loads go to WB, stores go to FETCH.
  - wait_cnt clears on MEM entry and increments on each MEM cycle with mem_ready low.
  - With MEM_TIMEOUT ≠ 0, mem_ready low while wait_cnt = MEM_TIMEOUT−1 sends the FSM to FAULT.
  - If mem_ready is high on the timeout cycle, ready wins.
- **WB:** reg_wr = 1. For CALL, also pc_wr with pc_src = 1. Next FETCH.
- **FAULT:** sticky until reset. All strobes 0, fault = 1, retire_cnt frozen.
- **retire_cnt:** increments by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB.

## Timing
- **Reset:** while reset is high, state = FETCH, all strobes = 0, fault = 0, retire_cnt = 0, wait_cnt = 0.
  - Static selects still follow opcode during reset.
  - The first FETCH strobe occurs in the first cycle after reset falls.
- **Reset mid-operation:** a reset in any state, including mid-MEM, aborts immediately. No strobe is issued in the reset cycle.
- **Cycles per instruction (W = MEM cycles before mem_ready):**
  - JMP, RET: 2.
  - Branch, CALL: 3.
  - R-type, ADDI, ANDI: 4.
  - SW, SV: 3+W+1.
  - LW, LB: 4+W+1.
- **Strobes:** Moore outputs of state plus the registered opcode; no input-to-strobe path except branch_taken→pc_wr in EXEC.
- **mem_ready outside MEM:** ignored.
- **Counter wrap:** retire_cnt at all-ones wraps to 0 on the next retirement.

## Test plan
- Reset held 3 cycles, then ADDI (3) → states 0,1,2,4 then 0; reg_wr high only in WB; ext_op = 1, alu_src = 1; retire_cnt = 1.
- LB with mode = 1 and mem_ready high on the 3rd MEM cycle → mem_rd high exactly 3 cycles; ext_op_mem = 1, mem_out = 1, wb_sel = 1; WB follows; 7 cycles total.
- SW with mem_ready never asserted, MEM_TIMEOUT = 4 → mem_wr high 4 cycles, then state = 5, fault = 1 stays high; retire_cnt unchanged; reset returns state = 0.
- Branch (8) with mode = 1 → ra_src = 2. branch_taken = 1 gives pc_wr = 1, pc_src = 3 in EXEC; branch_taken = 0 gives pc_wr = 0; both take 3 cycles.
- CALL then RET → CALL: WB with reg_wr = 1, reg_dst = 1, wb_sel = 2, pc_src = 1. RET: pc_wr in DECODE with pc_src = 2, ra_src = 1. retire_cnt += 2.
- OPCODE_W = 5, opcode 5'h12 → FAULT directly from DECODE. Also: CNT_W = 2 with 5 JMPs → retire_cnt reads 1 (wrap).

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle 16-bit RISC datapath: static opcode decode plus FETCH/DECODE/EXEC/MEM/WB FSM.
// Strobes are Moore outputs of state and the IR opcode (except branch_taken->pc_wr in EXEC); MEM waits on mem_ready with an optional timeout to FAULT.
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                pc_wr,
  output logic                ir_wr,
  output logic                reg_wr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [1:0]          pc_src,
  output logic [1:0]          ra_src,
  output logic [1:0]          wb_sel,
  output logic                rb_src,
  output logic                reg_dst,
  output logic                ext_op,
  output logic                alu_src,
  output logic                sv_imm,
  output logic                ext_op_mem,
  output logic                mem_out,
  output logic [2:0]          state,
  output logic                fault,
  output logic [CNT_W-1:0]    retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  localparam int WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam int TMO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [WAIT_W-1:0] TMO_LAST_V = WAIT_W'(TMO_LAST);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

  logic       legal;
  logic [3:0] op;
  logic       is_jmp, is_call, is_ret, is_branch, is_alu, is_load, is_store;

  // Anything outside the 16 defined opcodes traps, however wide the field is.
  assign legal     = (32'(opcode) < 32'd16);
  assign op        = opcode[3:0];
  assign is_jmp    = legal && (op == 4'd12);
  assign is_call   = legal && (op == 4'd13);
  assign is_ret    = legal && (op == 4'd14);
  assign is_branch = legal && (op[3:2] == 2'b10);
  assign is_alu    = legal && (op <= 4'd4);
  assign is_load   = legal && ((op == 4'd5) || (op == 4'd6));
  assign is_store  = legal && ((op == 4'd7) || (op == 4'd15));

  always_comb begin
    rb_src     = 1'b0;
    reg_dst    = 1'b0;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    sv_imm     = 1'b0;
    ext_op_mem = 1'b0;
    mem_out    = 1'b0;
    ra_src     = 2'd0;
    wb_sel     = 2'd0;
    if (legal) begin
      case (op)
        4'd3: begin
          ext_op  = 1'b1;
          alu_src = 1'b1;
        end
        4'd4: alu_src = 1'b1;
        4'd5, 4'd6: begin
          rb_src  = 1'b1;
          ext_op  = 1'b1;
          alu_src = 1'b1;
          wb_sel  = 2'd1;
          if (op == 4'd6) begin
            mem_out    = 1'b1;
            ext_op_mem = mode;
          end
        end
        4'd7: begin
          rb_src  = 1'b1;
          ext_op  = 1'b1;
          alu_src = 1'b1;
        end
        4'd8, 4'd9, 4'd10, 4'd11: begin
          rb_src = 1'b1;
          ra_src = mode ? 2'd2 : 2'd0;
        end
        4'd13: begin
          reg_dst = 1'b1;
          wb_sel  = 2'd2;
        end
        4'd14: ra_src = 2'd1;
        4'd15: begin
          ext_op = 1'b1;
          sv_imm = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    retire_cnt_d = retire_cnt_q;
    pc_wr        = 1'b0;
    ir_wr        = 1'b0;
    reg_wr       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    pc_src       = 2'd0;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_FAULT;
        end else if (is_jmp) begin
          pc_wr   = 1'b1;
          pc_src  = 2'd1;
          state_d = S_FETCH;
        end else if (is_ret) begin
          pc_wr   = 1'b1;
          pc_src  = 2'd2;
          state_d = S_FETCH;
        end else if (is_call) begin
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_wr   = branch_taken;
          pc_src  = 2'd3;
          state_d = S_FETCH;
        end else if (is_alu) begin
          state_d = S_WB;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_rd = is_load;
        mem_wr = is_store;
        // Ready takes priority over an expiring timeout in the same cycle.
        if (mem_ready) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TMO_LAST_V)) begin
            state_d = S_FAULT;
          end
        end
      end
      S_WB: begin
        reg_wr = 1'b1;
        if (is_call) begin
          pc_wr  = 1'b1;
          pc_src = 2'd1;
        end
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase

    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_FAULT)) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end

    // Reset aborts in the same cycle, so no strobe may escape it.
    if (reset) begin
      pc_wr  = 1'b0;
      ir_wr  = 1'b0;
      reg_wr = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign state      = state_q;
  assign fault      = (state_q == S_FAULT) && !reset;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected cycle traces built from instruction class.
// Directed scenarios followed by randomized instructions, memory latencies and branch outcomes.
module tb_multicycle_control_fsm;
  localparam int OPCODE_W    = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [OPCODE_W-1:0] opcode;
  logic                mode, branch_taken, mem_ready;
  logic                pc_wr, ir_wr, reg_wr, mem_rd, mem_wr;
  logic [1:0]          pc_src, ra_src, wb_sel;
  logic                rb_src, reg_dst, ext_op, alu_src, sv_imm, ext_op_mem, mem_out;
  logic [2:0]          state;
  logic                fault;
  logic [CNT_W-1:0]    retire_cnt;

  int checks  = 0;
  int errors  = 0;
  int retired = 0;

  multicycle_control_fsm #(
    .OPCODE_W(OPCODE_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mode(mode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .pc_src(pc_src), .ra_src(ra_src), .wb_sel(wb_sel),
    .rb_src(rb_src), .reg_dst(reg_dst), .ext_op(ext_op), .alu_src(alu_src),
    .sv_imm(sv_imm), .ext_op_mem(ext_op_mem), .mem_out(mem_out),
    .state(state), .fault(fault), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trace entry: {state[2:0], fault, pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, pc_src[1:0]}
  function automatic logic [10:0] ent(int st, bit pw, bit iw, bit rw, bit mr, bit mw, int ps);
    logic [2:0] s;
    logic [1:0] p;
    s = st[2:0];
    p = ps[1:0];
    return {s, (st == 5), pw, iw, rw, mr, mw, p};
  endfunction

  // Static selects: {rb_src, reg_dst, ext_op, alu_src, sv_imm, ext_op_mem, mem_out, ra_src, wb_sel}
  function automatic logic [10:0] sel_exp(int op, bit md);
    bit rb, rd, eo, as, sv, eom, mo;
    logic [1:0] ra, wb;
    {rb, rd, eo, as, sv, eom, mo} = 7'b0;
    ra = 2'd0;
    wb = 2'd0;
    if (op == 3) begin eo = 1; as = 1; end
    else if (op == 4) as = 1;
    else if (op == 5 || op == 6) begin
      rb = 1; eo = 1; as = 1; wb = 2'd1;
      if (op == 6) begin mo = 1; eom = md; end
    end
    else if (op == 7) begin rb = 1; eo = 1; as = 1; end
    else if (op >= 8 && op <= 11) begin rb = 1; ra = md ? 2'd2 : 2'd0; end
    else if (op == 13) begin rd = 1; wb = 2'd2; end
    else if (op == 14) ra = 2'd1;
    else if (op == 15) begin eo = 1; sv = 1; end
    return {rb, rd, eo, as, sv, eom, mo, ra, wb};
  endfunction

  function automatic logic [10:0] sel_obs();
    return {rb_src, reg_dst, ext_op, alu_src, sv_imm, ext_op_mem, mem_out, ra_src, wb_sel};
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset        = 1'b1;
      mem_ready    = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      chk("rst_strobes", 32'({pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, fault}), 0);
      chk("rst_selects", 32'(sel_obs()), 32'(sel_exp(int'(opcode), mode)));
      if (i > 0) chk("rst_state_cnt", 32'({state, retire_cnt}), 0);
    end
    retired = 0;
  endtask

  // w = MEM cycles with mem_ready low before it rises; abort_at >= 0 asserts reset at that trace cycle.
  task automatic run_instr(input int op, input bit md, input bit bt, input int w, input int abort_at);
    logic [10:0] tr[$];
    bit          faults;
    bit          ld;
    int          midx;
    logic [1:0]  ps_obs;
    faults = 0;
    midx   = 0;
    ld     = (op == 5 || op == 6);
    tr.push_back(ent(0, 1, 1, 0, 0, 0, 0));
    if (op >= 16) begin
      tr.push_back(ent(1, 0, 0, 0, 0, 0, 0));
      faults = 1;
    end else if (op == 12) tr.push_back(ent(1, 1, 0, 0, 0, 0, 1));
    else if (op == 14) tr.push_back(ent(1, 1, 0, 0, 0, 0, 2));
    else begin
      tr.push_back(ent(1, 0, 0, 0, 0, 0, 0));
      if (op == 13) tr.push_back(ent(4, 1, 0, 1, 0, 0, 1));
      else if (op >= 8 && op <= 11) tr.push_back(ent(2, bt, 0, 0, 0, 0, 3));
      else if (op <= 4) begin
        tr.push_back(ent(2, 0, 0, 0, 0, 0, 0));
        tr.push_back(ent(4, 0, 0, 1, 0, 0, 0));
      end else begin
        tr.push_back(ent(2, 0, 0, 0, 0, 0, 0));
        if (w >= MEM_TIMEOUT) begin
          for (int k = 0; k < MEM_TIMEOUT; k++) tr.push_back(ent(3, 0, 0, 0, ld, !ld, 0));
          faults = 1;
        end else begin
          for (int k = 0; k <= w; k++) tr.push_back(ent(3, 0, 0, 0, ld, !ld, 0));
          if (ld) tr.push_back(ent(4, 0, 0, 1, 0, 0, 0));
        end
      end
    end
    if (faults) repeat (3) tr.push_back(ent(5, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      opcode       = OPCODE_W'(op);
      mode         = md;
      reset        = 1'b0;
      branch_taken = (tr[i][10:8] == 3'd2) ? bt : 1'($urandom);
      mem_ready    = (tr[i][10:8] == 3'd3) ? (midx == w) : 1'($urandom);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_strobes", 32'({pc_wr, ir_wr, reg_wr, mem_rd, mem_wr}), 0);
        do_reset(2);
        return;
      end
      if (tr[i][10:8] == 3'd3) midx++;
      #1;
      ps_obs = tr[i][6] ? pc_src : tr[i][1:0];
      if (i == 0) chk("retire_cnt", 32'(retire_cnt), retired % (1 << CNT_W));
      if (i == 1) chk("selects", 32'(sel_obs()), 32'(sel_exp(op, md)));
      if (tr[i][10:8] == 3'd5) chk("fault_cnt_frozen", 32'(retire_cnt), retired % (1 << CNT_W));
      chk("cycle", 32'({state, fault, pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, ps_obs}), 32'(tr[i]));
    end
    if (faults) do_reset(2);
    else retired++;
  endtask

  initial begin
    int op, w;
    opcode       = OPCODE_W'(3);
    mode         = 1'b0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    reset        = 1'b1;
    do_reset(3);
    run_instr(3, 0, 0, 0, -1);      // ADDI
    run_instr(6, 1, 0, 2, -1);      // LB, ready on 3rd MEM cycle
    run_instr(7, 0, 0, 99, -1);     // SW, ready never comes
    run_instr(8, 1, 1, 0, -1);      // branch taken
    run_instr(8, 1, 0, 0, -1);      // branch not taken
    run_instr(13, 0, 0, 0, -1);     // CALL
    run_instr(14, 0, 0, 0, -1);     // RET
    run_instr(18, 0, 0, 0, -1);     // illegal 5'h12
    repeat (9) run_instr(12, 0, 0, 0, -1);
    run_instr(4, 0, 0, 0, -1);      // sees wrapped count
    run_instr(15, 0, 0, 3, -1);     // SV, ready on the timeout cycle
    run_instr(5, 0, 0, 3, 4);       // LW, reset in 2nd MEM cycle
    run_instr(3, 1, 0, 0, -1);
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
      w  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      run_instr(op, 1'($urandom), 1'($urandom), w, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
